// File: rtl/bram2be_pipe.sv
// bram2be_pipe: true dual-port RAM with per-lane byte enables, per-port read-during-write
// mode and a 1..4 register output pipe with valid strobe. Optional: BRAM2BE_COLLISION_FLAG_EN.
module bram2be_pipe #(
  parameter int ADDR_WIDTH  = 10,
  parameter int DATA_WIDTH  = 32,
  parameter int CHUNKSIZE   = 8,
  parameter int WE_WIDTH    = 4,
  parameter int MEMSIZE     = 1024,
  parameter int PIPE_STAGES = 1,
  parameter int RDW_MODE_A  = 0,
  parameter int RDW_MODE_B  = 0
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  ENA,
  input  logic [WE_WIDTH-1:0]   WEA,
  input  logic [ADDR_WIDTH-1:0] ADDRA,
  input  logic [DATA_WIDTH-1:0] DIA,
  output logic [DATA_WIDTH-1:0] DOA,
  output logic                  DOA_VALID,
  input  logic                  ENB,
  input  logic [WE_WIDTH-1:0]   WEB,
  input  logic [ADDR_WIDTH-1:0] ADDRB,
  input  logic [DATA_WIDTH-1:0] DIB,
  output logic [DATA_WIDTH-1:0] DOB,
  output logic                  DOB_VALID
`ifdef BRAM2BE_COLLISION_FLAG_EN
  ,
  output logic                  COLLISION,
  output logic [ADDR_WIDTH-1:0] COLLISION_ADDR
`endif
);

  localparam int RDW_WRITE_FIRST = 0;
  localparam int RDW_READ_FIRST  = 1;
  localparam int RDW_NO_CHANGE   = 2;
  localparam logic [ADDR_WIDTH:0] MEM_LIM = (ADDR_WIDTH+1)'(MEMSIZE);

  if (PIPE_STAGES < 1 || PIPE_STAGES > 4) begin : g_bad_stages
    $error("bram2be_pipe: PIPE_STAGES must be 1..4");
  end
  if (DATA_WIDTH != WE_WIDTH * CHUNKSIZE) begin : g_bad_lanes
    $error("bram2be_pipe: DATA_WIDTH must equal WE_WIDTH*CHUNKSIZE");
  end
  if (MEMSIZE < 1 || MEMSIZE > (2 ** ADDR_WIDTH)) begin : g_bad_memsize
    $error("bram2be_pipe: MEMSIZE must be 1..2**ADDR_WIDTH");
  end
  if (RDW_MODE_A != RDW_WRITE_FIRST && RDW_MODE_A != RDW_READ_FIRST &&
      RDW_MODE_A != RDW_NO_CHANGE) begin : g_bad_mode_a
    $error("bram2be_pipe: RDW_MODE_A must be 0, 1 or 2");
  end
  if (RDW_MODE_B != RDW_WRITE_FIRST && RDW_MODE_B != RDW_READ_FIRST &&
      RDW_MODE_B != RDW_NO_CHANGE) begin : g_bad_mode_b
    $error("bram2be_pipe: RDW_MODE_B must be 0, 1 or 2");
  end

  function automatic logic [DATA_WIDTH-1:0] lane_merge(
    input logic [DATA_WIDTH-1:0] base,
    input logic [DATA_WIDTH-1:0] din,
    input logic [WE_WIDTH-1:0]   mask
  );
    logic [DATA_WIDTH-1:0] w;
    w = base;
    for (int i = 0; i < WE_WIDTH; i++) begin
      if (mask[i]) w[i*CHUNKSIZE +: CHUNKSIZE] = din[i*CHUNKSIZE +: CHUNKSIZE];
    end
    return w;
  endfunction

  function automatic logic rdw_has_result(
    input int                  mode,
    input logic [WE_WIDTH-1:0] we
  );
    return (we == '0) || (mode != RDW_NO_CHANGE);
  endfunction

  function automatic logic [DATA_WIDTH-1:0] rdw_result(
    input int                    mode,
    input logic [WE_WIDTH-1:0]   we,
    input logic [DATA_WIDTH-1:0] old_word,
    input logic [DATA_WIDTH-1:0] stored_word
  );
    if (we == '0 || mode == RDW_READ_FIRST) return old_word;
    return stored_word;
  endfunction

  logic [DATA_WIDTH-1:0] mem [0:MEMSIZE-1];

  logic                  acc_a, acc_b;
  logic                  in_a, in_b;
  logic                  coll;
  logic [WE_WIDTH-1:0]   wa, wb, wb_eff;
  logic [WE_WIDTH-1:0]   wr_a, wr_b;
  logic [DATA_WIDTH-1:0] old_a, old_b;
  logic [DATA_WIDTH-1:0] st_a, st_b;
  logic                  res_a_vld, res_b_vld;
  logic [DATA_WIDTH-1:0] res_a, res_b;

  // Access decode: accesses are ignored entirely while reset is held.
  assign acc_a = ENA & ~RST;
  assign acc_b = ENB & ~RST;
  assign in_a  = {1'b0, ADDRA} < MEM_LIM;
  assign in_b  = {1'b0, ADDRB} < MEM_LIM;
  assign coll  = acc_a & acc_b & (ADDRA == ADDRB);

  assign wa     = acc_a ? WEA : '0;
  assign wb     = acc_b ? WEB : '0;
  // Port A owns any lane both ports enable on a shared address.
  assign wb_eff = coll ? (wb & ~wa) : wb;
  assign wr_a   = in_a ? wa : '0;
  assign wr_b   = in_b ? wb_eff : '0;

  assign old_a = in_a ? mem[ADDRA] : '0;
  assign old_b = in_b ? mem[ADDRB] : '0;

  // Post-resolution word each port will see stored at its address.
  assign st_a = in_a ? lane_merge(lane_merge(old_a, DIB, coll ? wb : '0), DIA, wa) : '0;
  assign st_b = in_b ? lane_merge(lane_merge(old_b, DIA, coll ? wa : '0), DIB, wb_eff) : '0;

  assign res_a_vld = acc_a & rdw_has_result(RDW_MODE_A, WEA);
  assign res_b_vld = acc_b & rdw_has_result(RDW_MODE_B, WEB);
  assign res_a     = rdw_result(RDW_MODE_A, WEA, old_a, st_a);
  assign res_b     = rdw_result(RDW_MODE_B, WEB, old_b, st_b);

  always_ff @(posedge CLK) begin
    for (int i = 0; i < WE_WIDTH; i++) begin
      if (wr_a[i]) mem[ADDRA][i*CHUNKSIZE +: CHUNKSIZE] <= DIA[i*CHUNKSIZE +: CHUNKSIZE];
      if (wr_b[i]) mem[ADDRB][i*CHUNKSIZE +: CHUNKSIZE] <= DIB[i*CHUNKSIZE +: CHUNKSIZE];
    end
  end

  logic [DATA_WIDTH-1:0]  dat_a_p [PIPE_STAGES];
  logic [PIPE_STAGES-1:0] vld_a_p;
  logic [DATA_WIDTH-1:0]  dat_b_p [PIPE_STAGES];
  logic [PIPE_STAGES-1:0] vld_b_p;

  // Output pipe: stages without a new result hold data, only the valid bit drops.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      vld_a_p <= '0;
      for (int s = 0; s < PIPE_STAGES; s++) dat_a_p[s] <= '0;
    end else begin
      vld_a_p[0] <= res_a_vld;
      if (res_a_vld) dat_a_p[0] <= res_a;
      for (int s = 1; s < PIPE_STAGES; s++) begin
        vld_a_p[s] <= vld_a_p[s-1];
        if (vld_a_p[s-1]) dat_a_p[s] <= dat_a_p[s-1];
      end
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      vld_b_p <= '0;
      for (int s = 0; s < PIPE_STAGES; s++) dat_b_p[s] <= '0;
    end else begin
      vld_b_p[0] <= res_b_vld;
      if (res_b_vld) dat_b_p[0] <= res_b;
      for (int s = 1; s < PIPE_STAGES; s++) begin
        vld_b_p[s] <= vld_b_p[s-1];
        if (vld_b_p[s-1]) dat_b_p[s] <= dat_b_p[s-1];
      end
    end
  end

  assign DOA       = dat_a_p[PIPE_STAGES-1];
  assign DOA_VALID = vld_a_p[PIPE_STAGES-1];
  assign DOB       = dat_b_p[PIPE_STAGES-1];
  assign DOB_VALID = vld_b_p[PIPE_STAGES-1];

`ifdef BRAM2BE_COLLISION_FLAG_EN
  logic coll_evt;
  assign coll_evt = coll & ((WEA | WEB) != '0);

  // Sticky flag; the address of the first event is kept until reset.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      COLLISION      <= 1'b0;
      COLLISION_ADDR <= '0;
    end else if (coll_evt && !COLLISION) begin
      COLLISION      <= 1'b1;
      COLLISION_ADDR <= ADDRA;
    end
  end
`endif

endmodule

// File: tb/tb_bram2be_pipe.sv
// Directed + short random bench for bram2be_pipe: two builds share one stimulus stream
// (2-stage WRITE_FIRST/READ_FIRST and 4-stage WRITE_FIRST/NO_CHANGE), scored against a word model.
module tb_bram2be_pipe;

  localparam int MEMSZ = 1000;

  logic        CLK = 1'b0;
  logic        RST;
  logic        ENA, ENB;
  logic [3:0]  WEA, WEB;
  logic [9:0]  ADDRA, ADDRB;
  logic [31:0] DIA, DIB;

  logic [31:0] doa0, dob0, doa1, dob1;
  logic        doa0_v, dob0_v, doa1_v, dob1_v;
`ifdef BRAM2BE_COLLISION_FLAG_EN
  logic        coll0, coll1;
  logic [9:0]  caddr0, caddr1;
`endif

  always #5 CLK = ~CLK;

  bram2be_pipe #(
    .ADDR_WIDTH(10), .DATA_WIDTH(32), .CHUNKSIZE(8), .WE_WIDTH(4), .MEMSIZE(MEMSZ),
    .PIPE_STAGES(2), .RDW_MODE_A(0), .RDW_MODE_B(1)
  ) d0 (
    .CLK(CLK), .RST(RST),
    .ENA(ENA), .WEA(WEA), .ADDRA(ADDRA), .DIA(DIA), .DOA(doa0), .DOA_VALID(doa0_v),
    .ENB(ENB), .WEB(WEB), .ADDRB(ADDRB), .DIB(DIB), .DOB(dob0), .DOB_VALID(dob0_v)
`ifdef BRAM2BE_COLLISION_FLAG_EN
    , .COLLISION(coll0), .COLLISION_ADDR(caddr0)
`endif
  );

  bram2be_pipe #(
    .ADDR_WIDTH(10), .DATA_WIDTH(32), .CHUNKSIZE(8), .WE_WIDTH(4), .MEMSIZE(MEMSZ),
    .PIPE_STAGES(4), .RDW_MODE_A(0), .RDW_MODE_B(2)
  ) d1 (
    .CLK(CLK), .RST(RST),
    .ENA(ENA), .WEA(WEA), .ADDRA(ADDRA), .DIA(DIA), .DOA(doa1), .DOA_VALID(doa1_v),
    .ENB(ENB), .WEB(WEB), .ADDRB(ADDRB), .DIB(DIB), .DOB(dob1), .DOB_VALID(dob1_v)
`ifdef BRAM2BE_COLLISION_FLAG_EN
    , .COLLISION(coll1), .COLLISION_ADDR(caddr1)
`endif
  );

  typedef struct {
    int          due;
    logic [31:0] d;
  } exp_t;

  // Output index: 0 d0.A, 1 d0.B, 2 d1.A, 3 d1.B
  exp_t        q [4][$];
  logic [31:0] last [4];
  int          lat  [4] = '{2, 2, 4, 4};
  int          mode [4] = '{0, 1, 0, 2};
  logic [31:0] mm [0:MEMSZ-1];
  logic        coll_m;
  logic [9:0]  caddr_m;
  int          cyc;
  int          n_vec;
  int          n_bad;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s cyc=%0d observed=%h expected=%h", tag, cyc, obs, exp);
    end
  endtask

  function automatic logic [32:0] obs_of(input int k);
    case (k)
      0:       return {doa0_v, doa0};
      1:       return {dob0_v, dob0};
      2:       return {doa1_v, doa1};
      default: return {dob1_v, dob1};
    endcase
  endfunction

  task automatic check_all();
    logic [32:0] o;
    logic        ev;
    logic [31:0] ed;
    for (int k = 0; k < 4; k++) begin
      o  = obs_of(k);
      ev = (q[k].size() != 0) && (q[k][0].due == cyc);
      ed = ev ? q[k][0].d : last[k];
      chk($sformatf("valid[%0d]", k), {31'b0, o[32]}, {31'b0, ev});
      chk($sformatf("data[%0d]", k), o[31:0], ed);
      if (ev) begin
        last[k] = ed;
        void'(q[k].pop_front());
      end
    end
`ifdef BRAM2BE_COLLISION_FLAG_EN
    chk("coll0", {31'b0, coll0}, {31'b0, coll_m});
    chk("coll1", {31'b0, coll1}, {31'b0, coll_m});
    chk("caddr0", {22'b0, caddr0}, {22'b0, caddr_m});
    chk("caddr1", {22'b0, caddr1}, {22'b0, caddr_m});
`endif
  endtask

  task automatic push_res(input int k, input logic [3:0] we, input logic [31:0] old_w,
                          input logic [31:0] st_w);
    exp_t e;
    e.due = cyc + lat[k];
    if (we == 4'h0)        e.d = old_w;
    else if (mode[k] == 0) e.d = st_w;
    else if (mode[k] == 1) e.d = old_w;
    else                   return;
    q[k].push_back(e);
  endtask

  // Model the access presented now, then clock once and check every output.
  task automatic step();
    logic [31:0] oa, ob, sa, sb;
    bit ia, ib;
    ia = int'(ADDRA) < MEMSZ;
    ib = int'(ADDRB) < MEMSZ;
    if (!RST) begin
      oa = (ENA && ia) ? mm[ADDRA] : 32'h0;
      ob = (ENB && ib) ? mm[ADDRB] : 32'h0;
      if (ENB && ib)
        for (int l = 0; l < 4; l++) if (WEB[l]) mm[ADDRB][l*8 +: 8] = DIB[l*8 +: 8];
      if (ENA && ia)
        for (int l = 0; l < 4; l++) if (WEA[l]) mm[ADDRA][l*8 +: 8] = DIA[l*8 +: 8];
      sa = ia ? mm[ADDRA] : 32'h0;
      sb = ib ? mm[ADDRB] : 32'h0;
      if (ENA) begin
        push_res(0, WEA, oa, sa);
        push_res(2, WEA, oa, sa);
      end
      if (ENB) begin
        push_res(1, WEB, ob, sb);
        push_res(3, WEB, ob, sb);
      end
      if (ENA && ENB && ADDRA == ADDRB && (WEA | WEB) != 4'h0 && !coll_m) begin
        coll_m  = 1'b1;
        caddr_m = ADDRA;
      end
    end
    @(posedge CLK);
    cyc++;
    #1;
    check_all();
  endtask

  task automatic pa(input bit en, input logic [3:0] we, input int addr, input logic [31:0] d);
    ENA = en; WEA = we; ADDRA = 10'(addr); DIA = d;
  endtask

  task automatic pb(input bit en, input logic [3:0] we, input int addr, input logic [31:0] d);
    ENB = en; WEB = we; ADDRB = 10'(addr); DIB = d;
  endtask

  task automatic idle();
    pa(0, 4'h0, 0, 32'h0);
    pb(0, 4'h0, 0, 32'h0);
  endtask

  task automatic flush_model();
    for (int k = 0; k < 4; k++) begin
      q[k].delete();
      last[k] = 32'h0;
    end
    coll_m  = 1'b0;
    caddr_m = '0;
  endtask

  int addr_set [5] = '{0, 3, 5, 7, 9};

  initial begin
    n_vec = 0;
    n_bad = 0;
    cyc   = 0;
    RST   = 1'b1;
    idle();
    flush_model();
    step();
    step();
    RST = 1'b0;

    // Preload through port A (full-word writes only).
    pa(1, 4'hF, 0, 32'h0BADF00D); step();
    pa(1, 4'hF, 3, 32'h11223344); step();
    pa(1, 4'hF, 7, 32'h0000CAFE); step();
    pa(1, 4'hF, 9, 32'hAA000000); step();

    // Write then read-back on A.
    pa(1, 4'hF, 5, 32'hDEADBEEF); step();
    pa(1, 4'h0, 5, 32'h0);        step();
    idle();                       step();

    // Partial-lane write on B, then re-read.
    pb(1, 4'b0101, 3, 32'hAABBCCDD); step();
    pb(1, 4'h0, 3, 32'h0);           step();

    // Read, full write, re-read on B.
    pb(1, 4'h0, 7, 32'h0);        step();
    pb(1, 4'hF, 7, 32'h5555AAAA); step();
    pb(1, 4'h0, 7, 32'h0);        step();
    idle();                       step();

    // Same-address double write, then both ports read it back.
    pa(1, 4'b0011, 9, 32'hAAAAAAAA);
    pb(1, 4'b0110, 9, 32'hBBBBBBBB); step();
    pa(1, 4'h0, 9, 32'h0);
    pb(1, 4'h0, 9, 32'h0);           step();

    // A writes while B reads the same word; then different addresses in parallel.
    pa(1, 4'hF, 7, 32'h12345678);
    pb(1, 4'h0, 7, 32'h0);           step();
    pa(1, 4'hF, 3, 32'h01020304);
    pb(1, 4'hF, 5, 32'h0A0B0C0D);    step();
    idle();
    pb(1, 4'h0, 7, 32'h0);           step();

    for (int i = 0; i < 40; i++) begin
      pa($urandom_range(0, 1), 4'($urandom_range(0, 15)), addr_set[$urandom_range(0, 4)], $urandom);
      pb($urandom_range(0, 1), 4'($urandom_range(0, 15)), addr_set[$urandom_range(0, 4)], $urandom);
      step();
    end
    idle(); step();

    // Out-of-range write is dropped and reads back as zero; low addresses untouched.
    pa(1, 4'hF, 1010, 32'hCAFEBABE); step();
    pa(1, 4'h0, 1010, 32'h0);
    pb(1, 4'h0, 1023, 32'h0);        step();
    pa(1, 4'h0, 0, 32'h0);
    pb(1, 4'h0, 0, 32'h0);           step();
    idle();                          step();

    // Reset with reads in flight.
    pa(1, 4'h0, 3, 32'h0); step();
    pa(1, 4'h0, 5, 32'h0); step();
    pa(1, 4'h0, 7, 32'h0); step();
    idle();
    RST = 1'b1;
    #1;
    flush_model();
    check_all();
    pa(1, 4'hF, 5, 32'hFFFFFFFF);
    pb(1, 4'hF, 5, 32'hEEEEEEEE); step();
    idle();                       step();
    RST = 1'b0;
    for (int i = 0; i < 5; i++) step();
    pa(1, 4'h0, 3, 32'h0); pb(1, 4'h0, 5, 32'h0); step();
    pa(1, 4'h0, 5, 32'h0); pb(1, 4'h0, 7, 32'h0); step();
    pa(1, 4'h0, 7, 32'h0); pb(1, 4'h0, 3, 32'h0); step();
    idle();
    for (int i = 0; i < 6; i++) step();

    for (int k = 0; k < 4; k++) chk($sformatf("drain[%0d]", k), 32'(q[k].size()), 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/bram2be_pipe.md
Name: bram2be_pipe

Overview:
- True dual-port block RAM with per-port byte enables.
- Per-port read-during-write mode and configurable output pipeline depth (1–4 registers).
- Per-port read-data valid strobe, so consumers no longer count latency themselves.
- Deterministic same-address collision resolution; drop-in storage for dual-ported LVDS frame buffers and echo FIFOs.

Parameters:
ADDR_WIDTH, 10, address bits per port
DATA_WIDTH, 32, word width
CHUNKSIZE, 8, bits per byte-enable lane
WE_WIDTH, 4, lanes; DATA_WIDTH must equal WE_WIDTH*CHUNKSIZE
MEMSIZE, 1024, words; must be ≤ 2**ADDR_WIDTH
PIPE_STAGES, 1, output registers per port, legal 1..4; illegal value → elaboration error
RDW_MODE_A, 0, port A read-during-write: 0 WRITE_FIRST, 1 READ_FIRST, 2 NO_CHANGE
RDW_MODE_B, 0, same for port B

Ports:
CLK  in  1  single clock, both ports, rising edge
RST  in  1  asynchronous, active-high reset
ENA  in  1  port A access enable
WEA  in  WE_WIDTH  port A lane write enables; 0 = read
ADDRA  in  ADDR_WIDTH  port A word address
DIA  in  DATA_WIDTH  port A write data
DOA  out  DATA_WIDTH  port A read data
DOA_VALID  out  1  one-cycle strobe: DOA carries new data
ENB, WEB, ADDRB, DIB, DOB, DOB_VALID  same as port A, for port B

Behaviour:
- Reset: RST asserted clears all pipeline data registers and valid bits immediately (DOx=0, DOx_VALID=0). RAM contents are not reset.
- While RST is high, accesses are ignored: no write, no valid.
- Reset mid-pipeline flushes in-flight reads; no valid appears for them after deassert.
- Access: ENx=1 at edge N is accepted.
  - Lanes with WEx[i]=1 take DIx lane i; other lanes keep their old value.
  - Stage-1 register loads the port's result at edge N.
  - Each further stage shifts one register per edge; no stall or backpressure.
  - Latency: DOx and DOx_VALID update at edge N+PIPE_STAGES-1 (PIPE_STAGES=1 → visible right after edge N).
- Result per mode when WEx≠0:
  - WRITE_FIRST: merged word (new enabled lanes, old other lanes); valid asserted.
  - READ_FIRST: complete old word; valid asserted.
  - NO_CHANGE: no result, no valid; DOx holds its previous value.
- When WEx=0: stored word, valid asserted.
- A stage without a new result holds its data; only the valid bit clears. DOx therefore retains the last delivered word indefinitely.
- DOx_VALID is high exactly one cycle per delivered result. Back-to-back accesses give continuous valid.
- Cross-port, same cycle, same address:
  - Both write: per lane, A wins where both lanes are enabled; B's lane is written where only B enables.
  - One port reads while the other writes: the reader gets the pre-write word.
  - A writing port's own result still follows its own RDW_MODE on the stored (post-resolution) word.
- Out of range (ADDRx ≥ MEMSIZE): write is dropped; read returns all zeros with valid asserted.
- Ports are independent: simultaneous accesses to different addresses do not interact.

Optional Feature:
- Macro: BRAM2BE_COLLISION_FLAG_EN.
- Defined: adds outputs COLLISION (1) and COLLISION_ADDR (ADDR_WIDTH).
  - Any cycle with ENA&ENB, ADDRA==ADDRB, and (WEA|WEB)≠0 sets sticky COLLISION one edge later.
  - COLLISION_ADDR captures the address of the first such event only.
  - Both clear only on RST.
- Undefined: ports absent, no collision logic; data behaviour is identical in both builds.

Test Plan:
- PIPE_STAGES=2, WRITE_FIRST: A writes 0xDEADBEEF to addr 5, WEA=4'hF; next cycle A reads 5. Write result appears at edge+1 with DOA_VALID; read returns 0xDEADBEEF with valid at edge+2.
- Byte enable, READ_FIRST: addr 3 holds 0x11223344; B writes 0xAABBCCDD, WEB=4'b0101 → DOB=0x11223344. Then B reads 3 → 0x11BB33DD.
- NO_CHANGE: B reads addr 7 (0x0000CAFE) → DOB=0x0000CAFE. B writes addr 7 → DOB_VALID stays 0 and DOB holds 0x0000CAFE; re-read returns the new data.
- Collision: A writes 0xAAAAAAAA WEA=4'b0011, B writes 0xBBBBBBBB WEB=4'b0110, both addr 9 in the same cycle → stored 0xAABBAAAA. With the macro defined, COLLISION=1 and COLLISION_ADDR=9.
- Reset mid-flight: PIPE_STAGES=4, issue 3 consecutive reads, assert RST one cycle later → DOA=0 and DOA_VALID=0 immediately; no valids after deassert; RAM contents intact on re-read.
- Out of range: MEMSIZE=1000, A writes addr 1010 then reads it → DOA=0 with valid; addr 1010−1024 aliasing not written (addr 0 unchanged).
